ps2_key_sequencer: RTL and testbench

- Consumes the byte stream from the PS/2 receiver: one scan code per strobe.
- Sequences multi-byte make/break codes (0xE0 extended prefix, 0xF0 break prefix) through an FSM.
- Keeps a registered pressed/released vector for N-1 tracked keys and issues one press or release event per real state change over a valid/ready handshake.
- Sits between the PS/2 byte receiver and game logic. It replaces edge-clocked per-key flops with a single clk domain.

---
 rtl/ps2_key_pkg.sv | 52 +++++
 rtl/ps2_evt_slot.sv | 57 +++++
 rtl/ps2_key_sequencer.sv | 137 +++++++++++++
 tb/tb_ps2_key_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared types, scan-code constants and tracked-key lookup
// for the PS/2 key sequencer.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_OVR0 = 8'h00;
  localparam logic [7:0] SC_OVR1 = 8'hFF;

  localparam int NKEYS = 7;

  // Index i lives at [i*8 +: 8]: W A S D Space Enter Esc
  localparam logic [NKEYS*8-1:0] KEY_TAB = {
    8'h76, 8'h5A, 8'h29, 8'h23,
    8'h1B, 8'h1C, 8'h1D
  };

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_lut_t;

  function automatic key_lut_t key_lookup(
    input logic [7:0] code
  );
    key_lut_t r;
    r = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (KEY_TAB[i*8 +: 8] == code) begin
        r.hit = 1'b1;
        r.idx = 3'(i);
      end
    end
    return r;
  endfunction

  // Keyboard self-test / ack / resend / echo replies
  function automatic logic is_ctrl(
    input logic [7:0] code
  );
    return (code == 8'hAA) || (code == 8'hFA) ||
           (code == 8'hFE) || (code == 8'hEE);
  endfunction

endpackage

// File: rtl/ps2_evt_slot.sv
// One-entry event register with valid/ready and sticky overflow.
// gen_* loads an event; evt_* presents it until accepted.
module ps2_evt_slot #(
  parameter int KW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gen_i,
  input  logic [KW-1:0] gen_key_i,
  input  logic          gen_press_i,
  input  logic          evt_ready_i,
  input  logic          overflow_clr_i,
  output logic          evt_valid_o,
  output logic [KW-1:0] evt_key_o,
  output logic          evt_press_o,
  output logic          evt_overflow_o
);

  logic          valid_q;
  logic [KW-1:0] key_q;
  logic          press_q;
  logic          ovf_q;
  logic          free;
  logic          drop;

  // Slot can take a new event if empty or draining this cycle
  assign free = !valid_q || evt_ready_i;
  assign drop = gen_i && !free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      press_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (gen_i && free) begin
        valid_q <= 1'b1;
        key_q   <= gen_key_i;
        press_q <= gen_press_i;
      end else if (valid_q && evt_ready_i) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign evt_valid_o    = valid_q;
  assign evt_key_o      = key_q;
  assign evt_press_o    = press_q;
  assign evt_overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes, tracks
// held keys and emits press/release events via ps2_evt_slot.
module ps2_key_sequencer
  import ps2_key_pkg::*;
#(
  parameter int  N              = 8,
  parameter int  TIMEOUT_CYCLES = 50000,
  localparam int KW             = $clog2(N-1),
  localparam int CW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_valid,
  input  logic [7:0]    scan_data,
  input  logic          scan_error,
  output logic [N-2:0]  key_pressed,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [KW-1:0] evt_key,
  output logic          evt_press,
  output logic          evt_overflow,
  input  logic          overflow_clr
);

  localparam logic [CW-1:0] TO_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-2:0]  keys_q, keys_d;

  key_lut_t      lk;
  logic          hit;
  logic [KW-1:0] kidx;
  logic          ovr;
  logic          gen;
  logic          gen_press;

  assign lk   = key_lookup(scan_data);
  assign hit  = lk.hit && (int'(lk.idx) < N - 1);
  assign kidx = KW'(lk.idx);
  assign ovr  = (scan_data == SC_OVR0) ||
                (scan_data == SC_OVR1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    gen       = 1'b0;
    gen_press = 1'b0;
    if (scan_error) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (scan_valid) begin
      cnt_d = '0;
      if (ovr) begin
        keys_d  = '0;
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            unique case (1'b1)
              (scan_data == SC_EXT):
                state_d = ST_EXT;
              (scan_data == SC_BRK):
                state_d = ST_BRK;
              default: begin
                if (!is_ctrl(scan_data) && hit &&
                    !keys_q[kidx]) begin
                  keys_d[kidx] = 1'b1;
                  gen          = 1'b1;
                  gen_press    = 1'b1;
                end
              end
            endcase
          end
          ST_EXT: begin
            state_d = (scan_data == SC_BRK) ?
                      ST_EXT_BRK : ST_IDLE;
          end
          ST_BRK: begin
            state_d = ST_IDLE;
            if (hit && keys_q[kidx]) begin
              keys_d[kidx] = 1'b0;
              gen          = 1'b1;
            end
          end
          ST_EXT_BRK: begin
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // Abandon a prefix whose follow-up byte never came
      if (cnt_q == TO_MAX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
    end
  end

  assign key_pressed = keys_q;

  ps2_evt_slot #(
    .KW(KW)
  ) u_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .gen_i         (gen),
    .gen_key_i     (kidx),
    .gen_press_i   (gen_press),
    .evt_ready_i   (evt_ready),
    .overflow_clr_i(overflow_clr),
    .evt_valid_o   (evt_valid),
    .evt_key_o     (evt_key),
    .evt_press_o   (evt_press),
    .evt_overflow_o(evt_overflow)
  );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: cycle model
// plus directed scan-code sequences with literal checks.
module tb_ps2_key_sequencer;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       scan_error;
  logic [6:0] key_pressed;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;
  logic       evt_overflow;
  logic       overflow_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int hs    = 0;

  ps2_key_sequencer #(
    .N(8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_valid  (scan_valid),
    .scan_data   (scan_data),
    .scan_error  (scan_error),
    .key_pressed (key_pressed),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_press   (evt_press),
    .evt_overflow(evt_overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         keymap[bit [7:0]];
  bit [6:0]   m_keys = '0;
  bit         m_e0   = 1'b0;
  bit         m_f0   = 1'b0;
  int         m_wait = 0;
  bit         m_v    = 1'b0;
  int         m_key  = 0;
  bit         m_pr   = 1'b0;
  bit         m_ovf  = 1'b0;

  initial begin
    keymap[8'h1D] = 0;
    keymap[8'h1C] = 1;
    keymap[8'h1B] = 2;
    keymap[8'h23] = 3;
    keymap[8'h29] = 4;
    keymap[8'h5A] = 5;
    keymap[8'h76] = 6;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_keys = '0;
      m_e0   = 1'b0;
      m_f0   = 1'b0;
      m_wait = 0;
      m_v    = 1'b0;
      m_key  = 0;
      m_pr   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      bit       g;
      bit       gp;
      int       gk;
      bit [7:0] d;
      bit       ctl;
      g  = 1'b0;
      gp = 1'b0;
      gk = 0;
      d  = scan_data;
      ctl = (d == 8'hAA) || (d == 8'hFA) ||
            (d == 8'hFE) || (d == 8'hEE);
      if (scan_error) begin
        m_e0 = 0;
        m_f0 = 0;
        m_wait = 0;
      end else if (scan_valid) begin
        m_wait = 0;
        if (d == 8'h00 || d == 8'hFF) begin
          m_keys = '0;
          m_e0 = 0;
          m_f0 = 0;
        end else if (!m_e0 && !m_f0) begin
          if (d == 8'hE0) m_e0 = 1;
          else if (d == 8'hF0) m_f0 = 1;
          else if (!ctl && keymap.exists(d)) begin
            gk = keymap[d];
            if (!m_keys[gk]) begin
              m_keys[gk] = 1'b1;
              g = 1;
              gp = 1;
            end
          end
        end else if (m_e0 && !m_f0) begin
          if (d == 8'hF0) m_f0 = 1;
          else m_e0 = 0;
        end else if (!m_e0 && m_f0) begin
          m_f0 = 0;
          if (keymap.exists(d)) begin
            gk = keymap[d];
            if (m_keys[gk]) begin
              m_keys[gk] = 1'b0;
              g = 1;
            end
          end
        end else begin
          m_e0 = 0;
          m_f0 = 0;
        end
      end else if (m_e0 || m_f0) begin
        m_wait++;
        if (m_wait >= T) begin
          m_e0 = 0;
          m_f0 = 0;
          m_wait = 0;
        end
      end
      if (overflow_clr) m_ovf = 1'b0;
      if (g) begin
        if (!m_v || evt_ready) begin
          m_v   = 1'b1;
          m_key = gk;
          m_pr  = gp;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_v && evt_ready) begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_keys", 32'(key_pressed), 32'(m_keys));
    chk("m_valid", 32'(evt_valid), 32'(m_v));
    chk("m_ovf", 32'(evt_overflow), 32'(m_ovf));
    if (m_v) begin
      chk("m_key", 32'(evt_key), 32'(m_key));
      chk("m_press", 32'(evt_press), 32'(m_pr));
    end
  end

  always @(posedge clk)
    if (rst_n && evt_valid && evt_ready) hs++;

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [7:0] b,
    input logic       clr = 1'b0
  );
    scan_valid   = 1'b1;
    scan_data    = b;
    overflow_clr = clr;
    @(posedge clk);
    #1;
    scan_valid   = 1'b0;
    overflow_clr = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    scan_valid   = 1'b0;
    scan_data    = 8'h00;
    scan_error   = 1'b0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_keys", 32'(key_pressed), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_key", 32'(evt_key), 0);
    chk("rst_press", 32'(evt_press), 0);
    chk("rst_ovf", 32'(evt_overflow), 0);
    rst_n = 1'b1;
    idle(2);

    // press / release W
    send(8'h1D);
    chk("w_keys", 32'(key_pressed), 32'h01);
    chk("w_valid", 32'(evt_valid), 1);
    chk("w_key", 32'(evt_key), 0);
    chk("w_press", 32'(evt_press), 1);
    evt_ready = 1'b1;
    idle(1);
    evt_ready = 1'b0;
    chk("w_drain", 32'(evt_valid), 0);
    send(8'hF0);
    chk("w_pend", 32'(evt_valid), 0);
    send(8'h1D);
    chk("wr_keys", 32'(key_pressed), 0);
    chk("wr_valid", 32'(evt_valid), 1);
    chk("wr_press", 32'(evt_press), 0);
    evt_ready = 1'b1;
    idle(2);

    // typematic repeat
    hs = 0;
    send(8'h1D);
    send(8'h1D);
    send(8'h1D);
    idle(2);
    chk("typ_events", 32'(hs), 1);
    chk("typ_keys", 32'(key_pressed), 32'h01);
    send(8'hF0);
    send(8'h1D);
    idle(2);

    // back-to-back press while draining
    send(8'h1B);
    send(8'h23);
    chk("b2b_valid", 32'(evt_valid), 1);
    chk("b2b_key", 32'(evt_key), 3);
    idle(2);
    send(8'hF0);
    send(8'h1B);
    send(8'hF0);
    send(8'h23);
    idle(2);

    // extended codes ignored
    hs = 0;
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'h1D);
    send(8'hAA);
    idle(2);
    chk("ext_events", 32'(hs), 0);
    chk("ext_keys", 32'(key_pressed), 0);
    send(8'h1C);
    idle(2);
    chk("ext_idle", 32'(hs), 1);
    chk("ext_keys2", 32'(key_pressed), 32'h02);
    send(8'hF0);
    send(8'h1C);
    idle(2);

    // overflow
    evt_ready = 1'b0;
    send(8'h1D);
    send(8'h1C);
    chk("ovf_key", 32'(evt_key), 0);
    chk("ovf_press", 32'(evt_press), 1);
    chk("ovf_flag", 32'(evt_overflow), 1);
    chk("ovf_keys", 32'(key_pressed), 32'h03);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(evt_overflow), 0);
    chk("ovf_hold", 32'(evt_valid), 1);
    send(8'h1B, 1'b1);
    chk("ovf_setwins", 32'(evt_overflow), 1);
    chk("ovf_keys3", 32'(key_pressed), 32'h07);
    overflow_clr = 1'b1;
    evt_ready    = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    send(8'hF0);
    send(8'h1D);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h1B);
    idle(2);
    chk("ovf_rel", 32'(key_pressed), 0);

    // timeout
    hs = 0;
    send(8'hF0);
    idle(T);
    send(8'h1D);
    chk("to_keys", 32'(key_pressed), 32'h01);
    chk("to_press", 32'(evt_press), 1);
    idle(2);
    send(8'hF0);
    idle(T - 1);
    send(8'h1D);
    chk("to_edge", 32'(key_pressed), 0);
    chk("to_rel", 32'(evt_press), 0);
    idle(2);

    // scan error
    send(8'hF0);
    scan_error = 1'b1;
    idle(1);
    scan_error = 1'b0;
    send(8'h1D);
    chk("err_keys", 32'(key_pressed), 32'h01);
    chk("err_press", 32'(evt_press), 1);
    idle(2);

    // overrun
    send(8'h29);
    idle(2);
    chk("ovr_pre", 32'(key_pressed), 32'h11);
    hs = 0;
    send(8'hFF);
    chk("ovr_keys", 32'(key_pressed), 0);
    idle(2);
    chk("ovr_events", 32'(hs), 0);

    // reset mid-stream
    evt_ready = 1'b0;
    send(8'h1D);
    send(8'h1C);
    send(8'hE0);
    rst_n = 1'b0;
    #2;
    chk("mrst_keys", 32'(key_pressed), 0);
    chk("mrst_valid", 32'(evt_valid), 0);
    chk("mrst_key", 32'(evt_key), 0);
    chk("mrst_press", 32'(evt_press), 0);
    chk("mrst_ovf", 32'(evt_overflow), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    send(8'h1D);
    chk("post_keys", 32'(key_pressed), 32'h01);
    chk("post_valid", 32'(evt_valid), 1);
    chk("post_key", 32'(evt_key), 0);
    chk("post_press", 32'(evt_press), 1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
